debug_display_scanner: RTL and testbench

Downstream consumer of the stack CPU's debug outputs: takes the two 16-bit SEG words and six 16-bit trace words (pc, state, opcode, rom word, sp, ram addr) and shows one selected word at a time on a 4-digit multiplexed common-anode 7-segment display in hex. A debounced push-button steps through the pages. An optional timer auto-advances the page. The selected word is snapshotted once per scan frame, so the display never tears while the CPU runs.

---
 rtl/debug_display_pkg.sv | 36 +++
 rtl/hex_to_seg7.sv | 11 +
 rtl/debug_display_scanner.sv | 161 ++++++++++++++++
 tb/tb_debug_display_scanner.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared types and constants for the debug display scanner: page names and
// the active-low hex segment patterns.
package debug_display_pkg;

  typedef enum logic [2:0] {
    PG_SEG1   = 3'd0,
    PG_SEG2   = 3'd1,
    PG_PC     = 3'd2,
    PG_STATE  = 3'd3,
    PG_OPCODE = 3'd4,
    PG_ROM    = 3'd5,
    PG_SP     = 3'd6,
    PG_ADDR   = 3'd7
  } page_e;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [3:0] DIGITS_OFF = 4'hF;

  // Element [n] is the pattern for hex digit n; bit 7 (dp) is always dark.
  localparam logic [15:0][7:0] SEG_PATTERNS = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = word[3:0];
      2'd1:    nib = word[7:4];
      2'd2:    nib = word[11:8];
      default: nib = word[15:12];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern (dp off).
module hex_to_seg7
  import debug_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] segment_n
);

  assign segment_n = SEG_PATTERNS[nibble];

endmodule

// File: rtl/debug_display_scanner.sv
// Pages through the CPU SEG/trace words on a 4-digit multiplexed hex display.
// Optional build macro DSCAN_AUTO_PAGE_EN adds timed auto-advance of the page.
module debug_display_scanner
  import debug_display_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PAGE_HOLD       = 1000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] seg1,
  input  logic [15:0] seg2,
  input  logic [15:0] dbg1,
  input  logic [15:0] dbg2,
  input  logic [15:0] dbg3,
  input  logic [15:0] dbg4,
  input  logic [15:0] dbg5,
  input  logic [15:0] dbg6,
  input  logic        btn_next,
  input  logic        auto_en,
  output logic [3:0]  digit_sel_n,
  output logic [7:0]  segment_n,
  output logic [2:0]  page_idx
);

  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LIMIT = DEB_W'(DEBOUNCE_CYCLES);

  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_next;
  logic [1:0]        digit_idx;
  logic [1:0]        digit_next;
  logic [15:0]       snapshot;
  logic [15:0]       snap_next;
  logic              loaded;
  logic [15:0]       page_word;
  logic [3:0]        disp_nibble;
  logic [7:0]        disp_pattern;
  logic              slot_wrap;
  logic              frame_wrap;

  logic              sync_meta;
  logic              sync_level;
  logic              accepted;
  logic [DEB_W-1:0]  deb_cnt;
  logic              btn_step;
  logic              auto_step;
  page_e             page_reg;

  assign page_idx   = page_reg;
  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx == 2'd3);

  always_comb begin
    page_word = seg1;
    case (page_reg)
      PG_SEG1:   page_word = seg1;
      PG_SEG2:   page_word = seg2;
      PG_PC:     page_word = dbg1;
      PG_STATE:  page_word = dbg2;
      PG_OPCODE: page_word = dbg3;
      PG_ROM:    page_word = dbg4;
      PG_SP:     page_word = dbg5;
      PG_ADDR:   page_word = dbg6;
      default:   page_word = seg1;
    endcase
  end

  // Outputs are derived from next-state values so the new digit's pattern is
  // already on the segments during its blanked slot 0.
  always_comb begin
    slot_next  = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
    digit_next = slot_wrap ? digit_idx + 2'd1 : digit_idx;
    snap_next  = (frame_wrap || !loaded) ? page_word : snapshot;
  end

  assign disp_nibble = nibble_of(snap_next, digit_next);

  hex_to_seg7 u_hex_to_seg7 (
    .nibble    (disp_nibble),
    .segment_n (disp_pattern)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt    <= '0;
      digit_idx   <= 2'd0;
      snapshot    <= 16'h0000;
      loaded      <= 1'b0;
      digit_sel_n <= DIGITS_OFF;
      segment_n   <= SEG_BLANK;
    end else begin
      slot_cnt    <= slot_next;
      digit_idx   <= digit_next;
      snapshot    <= snap_next;
      loaded      <= 1'b1;
      segment_n   <= disp_pattern;
      digit_sel_n <= (slot_next == '0) ? DIGITS_OFF : ~(4'b0001 << digit_next);
    end
  end

  // Button: two-flop synchronizer, then a run-length debounce on the level.
  assign btn_step = sync_level && !accepted && (deb_cnt == DEB_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
      accepted   <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      sync_meta  <= btn_next;
      sync_level <= sync_meta;
      if (sync_level == accepted) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LIMIT) begin
        accepted <= sync_level;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

`ifdef DSCAN_AUTO_PAGE_EN
  localparam int FRAME_W = $clog2(PAGE_HOLD + 1);

  logic [FRAME_W-1:0] frame_cnt;
  logic [FRAME_W-1:0] frame_inc;

  assign frame_inc = frame_cnt + FRAME_W'(1);
  assign auto_step = auto_en && frame_wrap && (frame_inc == FRAME_W'(PAGE_HOLD));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (!auto_en) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= auto_step ? '0 : frame_inc;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = auto_en ^ PAGE_HOLD[0];
  assign auto_step   = 1'b0;
`endif

  // A coincident button accept and auto advance still move one page only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      page_reg <= PG_SEG1;
    end else if (btn_step || auto_step) begin
      page_reg <= page_e'(page_reg + 3'd1);
    end
  end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Self-checking bench for debug_display_scanner against a cycle-level reference model.
module tb_debug_display_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int HOLD     = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] seg1, seg2, dbg1, dbg2, dbg3, dbg4, dbg5, dbg6;
  logic        btn_next = 1'b0;
  logic        auto_en = 1'b0;
  logic [3:0]  digit_sel_n;
  logic [7:0]  segment_n;
  logic [2:0]  page_idx;

  int checks = 0;
  int failures = 0;

  debug_display_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .PAGE_HOLD       (HOLD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .seg1        (seg1),
    .seg2        (seg2),
    .dbg1        (dbg1),
    .dbg2        (dbg2),
    .dbg3        (dbg3),
    .dbg4        (dbg4),
    .dbg5        (dbg5),
    .dbg6        (dbg6),
    .btn_next    (btn_next),
    .auto_en     (auto_en),
    .digit_sel_n (digit_sel_n),
    .segment_n   (segment_n),
    .page_idx    (page_idx)
  );

  always #5 clock = ~clock;

  logic [7:0] hex_pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: edges since reset release, latched word, page, accepted level.
  int          cyc;
  logic [15:0] m_snap;
  int          m_page;
  bit          m_acc;
  bit          hist[$];
`ifdef DSCAN_AUTO_PAGE_EN
  int          m_frames;
`endif

  function automatic logic [15:0] word_at(input int p);
    case (p)
      0:       return seg1;
      1:       return seg2;
      2:       return dbg1;
      3:       return dbg2;
      4:       return dbg3;
      5:       return dbg4;
      6:       return dbg5;
      default: return dbg6;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    m_snap = 16'h0000;
    m_page = 0;
    m_acc = 1'b0;
    hist.delete();
`ifdef DSCAN_AUTO_PAGE_EN
    m_frames = 0;
`endif
  endtask

  // One clock: capture inputs, step the model at the edge, compare #1 later.
  task automatic tick();
    logic [15:0] w;
    bit          b;
    bit          btn_fire;
    bit          auto_fire;
    int          digit;
    int          slot;
    logic [3:0]  exp_sel;
    logic [3:0]  nib;
`ifdef DSCAN_AUTO_PAGE_EN
    bit          a;
    a = auto_en;
`endif
    w = word_at(m_page);
    b = btn_next;
    @(posedge clock);
    cyc++;
    if (cyc == 1 || cyc % FRAME == 0) m_snap = w;
    // The level flips once DEB+1 synchronized samples (2 edges late) all disagree with it.
    hist.push_back(b);
    if (hist.size() > DEB + 3) void'(hist.pop_front());
    btn_fire = 1'b0;
    if (hist.size() == DEB + 3) begin
      bit all_new;
      all_new = 1'b1;
      for (int i = 0; i <= DEB; i++) if (hist[i] == m_acc) all_new = 1'b0;
      if (all_new) begin
        m_acc = !m_acc;
        btn_fire = m_acc;
      end
    end
    auto_fire = 1'b0;
`ifdef DSCAN_AUTO_PAGE_EN
    if (!a) m_frames = 0;
    else if (cyc % FRAME == 0) begin
      m_frames++;
      if (m_frames == HOLD) begin
        m_frames = 0;
        auto_fire = 1'b1;
      end
    end
`endif
    if (btn_fire || auto_fire) m_page = (m_page + 1) % 8;
    #1;
    slot = cyc % SCAN_DIV;
    digit = (cyc / SCAN_DIV) % 4;
    exp_sel = (slot == 0) ? 4'hF : ~(4'b0001 << digit);
    nib = 4'((m_snap >> (4 * digit)) & 16'h000F);
    check("page", {13'd0, page_idx}, 16'(m_page));
    check("digit_sel", {12'd0, digit_sel_n}, {12'd0, exp_sel});
    check("segment", {8'd0, segment_n}, {8'd0, hex_pat[nib]});
  endtask

  task automatic clean_press();
    btn_next = 1'b1;
    repeat (12) tick();
    btn_next = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p0;
    int t0;
    seg1 = 16'h1234;
    seg2 = 16'($urandom);
    dbg1 = 16'($urandom); dbg2 = 16'($urandom); dbg3 = 16'($urandom);
    dbg4 = 16'($urandom); dbg5 = 16'($urandom); dbg6 = 16'($urandom);
    model_reset();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_sel", {12'd0, digit_sel_n}, 16'h000F);
    check("rst_seg", {8'd0, segment_n}, 16'h00FF);
    check("rst_page", {13'd0, page_idx}, 16'h0000);
    #1 reset_n = 1'b1;

    // First digit after release shows '4' of 1234
    tick();
    check("first_seg", {8'd0, segment_n}, 16'h0099);
    check("first_sel", {12'd0, digit_sel_n}, 16'h000E);

    // Mid-frame word change appears only at the next frame
    while (cyc < 6) tick();
    seg1 = 16'hABCD;
    while (cyc < 13) tick();
    check("old_frame_d3", {8'd0, segment_n}, 16'h00F9);
    while (cyc < 17) tick();
    check("new_frame_d0", {8'd0, segment_n}, 16'h00A1);

    // Short bounces never advance the page
    repeat (3) begin
      btn_next = 1'b1;
      repeat (5) tick();
      btn_next = 1'b0;
      repeat (5) tick();
    end
    repeat (12) tick();
    check("bounce_page", {13'd0, page_idx}, 16'h0000);

    // Clean 20-cycle press: latency and single increment
    lat = -1;
    btn_next = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 20) btn_next = 1'b0;
      if (lat < 0 && page_idx != 3'd0) lat = i;
    end
    check("press_latency", 16'(lat), 16'd11);
    check("press_once", {13'd0, page_idx}, 16'h0001);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 24);
      lo = $urandom_range(1, 24);
      seg1 = 16'($urandom); seg2 = 16'($urandom);
      dbg1 = 16'($urandom); dbg2 = 16'($urandom); dbg3 = 16'($urandom);
      dbg4 = 16'($urandom); dbg5 = 16'($urandom); dbg6 = 16'($urandom);
      auto_en = 1'($urandom_range(0, 1));
      btn_next = 1'b1;
      repeat (hi) tick();
      btn_next = 1'b0;
      repeat (lo) tick();
      $display("txn %0d press=%0d gap=%0d auto=%0d page=%0d checks=%0d", t, hi, lo, auto_en, page_idx, checks);
    end

    // Wrap 7 -> 0 with press plus release
    auto_en = 1'b0;
    for (int i = 0; i < 10 && m_page != 7; i++) clean_press();
    check("at_page7", {13'd0, page_idx}, 16'd7);
    clean_press();
    check("wrap_page", {13'd0, page_idx}, 16'd0);

`ifdef DSCAN_AUTO_PAGE_EN
    // Auto advance period, freeze, and coincidence with a button accept
    auto_en = 1'b1;
    p0 = m_page;
    for (int i = 0; i < 80 && m_page == p0; i++) tick();
    p0 = m_page;
    t0 = cyc;
    for (int i = 0; i < 80 && m_page == p0; i++) tick();
    check("auto_period", 16'(cyc - t0), 16'(2 * FRAME));
    auto_en = 1'b0;
    p0 = m_page;
    repeat (80) tick();
    check("auto_frozen", {13'd0, page_idx}, 16'(p0));
    auto_en = 1'b1;
    for (int i = 0; i < 100 && !(m_frames == HOLD - 1 && cyc % FRAME == 5); i++) tick();
    p0 = m_page;
    btn_next = 1'b1;
    repeat (11) tick();
    check("coincide", {13'd0, page_idx}, 16'((p0 + 1) % 8));
    btn_next = 1'b0;
    auto_en = 1'b0;
    repeat (14) tick();
`else
    // Without the auto build, auto_en has no effect
    p0 = m_page;
    t0 = cyc;
    auto_en = 1'b1;
    repeat (70) tick();
    check("auto_ignored", {13'd0, page_idx}, 16'(p0));
    check("auto_cycles", 16'(cyc - t0), 16'd70);
    auto_en = 1'b0;
`endif

    // Asynchronous reset mid-digit blanks without a clock edge
    clean_press();
    for (int i = 0; i < 8 && (cyc % SCAN_DIV) != 2; i++) tick();
    #3 reset_n = 1'b0;
    #1;
    check("async_sel", {12'd0, digit_sel_n}, 16'h000F);
    check("async_seg", {8'd0, segment_n}, 16'h00FF);
    check("async_page", {13'd0, page_idx}, 16'h0000);
    repeat (2) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
